// File: rtl/ram16_pkg.sv
// ram16_pkg -- shared state encoding and constants for the 16-bit SRAM controller.
// Rev 1.0
`default_nettype none

package ram16_pkg;

    localparam int WAIT_DEFAULT = 1;
    localparam int CNT_W        = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ram16_wcnt.sv
// ram16_wcnt -- 3-bit phase down-counter with load, decrement and zero flag.
// Rev 1.0
`default_nettype none

module ram16_wcnt
    import ram16_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt_nxt,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_load) begin
            w_cnt_nxt = i_load_val;
        end else if (i_dec) begin
            w_cnt_nxt = r_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Next value is exported so the owner can register outputs that depend on it.
    assign o_cnt_nxt = w_cnt_nxt;
    assign o_zero    = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/ram16_ctrl.sv
// ram16_ctrl -- 32-bit bus to 16-bit async SRAM bridge, two half-word phases per access.
// Rev 1.0
`default_nettype none

module ram16_ctrl
    import ram16_pkg::*;
#(
    parameter int WAIT = WAIT_DEFAULT
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_stb,
    input  logic        bus_we,
    input  logic [21:0] bus_addr,
    input  logic [31:0] bus_din,
    output logic [31:0] bus_dout,
    output logic        bus_ack,
    output logic [22:0] sram_a,
    output logic [15:0] sram_d_out,
    input  logic [15:0] sram_d_in,
    output logic        sram_d_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_lb_n,
    output logic        sram_ub_n
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_we;
    logic [21:0]      r_addr;
    logic [31:0]      r_din;
    logic [15:0]      r_rbuf_lo;

    logic             w_accept;
    logic             w_load;
    logic             w_dec;
    logic             w_zero;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_we_nxt;
    logic [21:0]      w_addr_nxt;
    logic [31:0]      w_din_nxt;
    logic             w_active_nxt;
    logic             w_hi_nxt;
    logic [22:0]      w_a_nxt;
    logic [15:0]      w_dout_nxt;
    logic             w_doe_nxt;
    logic             w_oe_n_nxt;
    logic             w_we_n_nxt;
    logic             w_ack_nxt;
    logic             w_lo_last;
    logic             w_hi_last;

    assign w_accept  = (r_state == ST_IDLE) && bus_stb;
    assign w_lo_last = (r_state == ST_LO) && w_zero;
    assign w_hi_last = (r_state == ST_HI) && w_zero;
    assign w_load    = w_accept || w_lo_last;
    assign w_dec     = ((r_state == ST_LO) || (r_state == ST_HI)) && !w_zero;

    ram16_wcnt u_wcnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (CNT_W'(WAIT)),
        .i_dec      (w_dec),
        .o_cnt_nxt  (w_cnt_nxt),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus_stb) w_state_nxt = ST_LO;
            ST_LO:   if (w_zero)  w_state_nxt = ST_HI;
            ST_HI:   if (w_zero)  w_state_nxt = ST_ACK;
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are computed for the upcoming cycle so every pin comes straight off a flop.
    always_comb begin
        w_we_nxt     = w_accept ? bus_we   : r_we;
        w_addr_nxt   = w_accept ? bus_addr : r_addr;
        w_din_nxt    = w_accept ? bus_din  : r_din;
        w_active_nxt = (w_state_nxt == ST_LO) || (w_state_nxt == ST_HI);
        w_hi_nxt     = (w_state_nxt == ST_HI);
        w_a_nxt      = w_active_nxt ? {w_addr_nxt, w_hi_nxt} : 23'd0;
        w_dout_nxt   = 16'd0;
        if (w_active_nxt && w_we_nxt) begin
            w_dout_nxt = w_hi_nxt ? w_din_nxt[31:16] : w_din_nxt[15:0];
        end
        w_doe_nxt    = w_active_nxt && w_we_nxt;
        w_oe_n_nxt   = !(w_active_nxt && !w_we_nxt);
        // Last cycle of a write phase releases WE for address/data hold.
        w_we_n_nxt   = !(w_active_nxt && w_we_nxt && (w_cnt_nxt != '0));
        w_ack_nxt    = (w_state_nxt == ST_ACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_din      <= '0;
            r_rbuf_lo  <= '0;
            bus_dout   <= '0;
            bus_ack    <= 1'b0;
            sram_a     <= '0;
            sram_d_out <= '0;
            sram_d_oe  <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
        end else begin
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_din      <= w_din_nxt;
            if (w_lo_last && !r_we) begin
                r_rbuf_lo <= sram_d_in;
            end
            if (w_hi_last && !r_we) begin
                bus_dout <= {sram_d_in, r_rbuf_lo};
            end
            bus_ack    <= w_ack_nxt;
            sram_a     <= w_a_nxt;
            sram_d_out <= w_dout_nxt;
            sram_d_oe  <= w_doe_nxt;
            sram_ce_n  <= !w_active_nxt;
            sram_oe_n  <= w_oe_n_nxt;
            sram_we_n  <= w_we_n_nxt;
            sram_lb_n  <= !w_active_nxt;
            sram_ub_n  <= !w_active_nxt;
        end
    end

endmodule

`default_nettype wire
